// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_XLEN = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_INC = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of {pc, instr} with flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with credit-limited prefetch and redirect flush.
// Optional stall counter port enabled by defining FETCH_PERF_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   count;
    logic [CW+1:0]   used;
    logic            credit;
    logic            req_fire;
    logic            rsp_keep;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic            unused_bits;
    fetch_entry_t    entry;
    fetch_entry_t    head;

    assign target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_bits = ^redirect_pc[1:0];

    // Stale fetches still occupy credit until their responses drain.
    assign used   = (CW+2)'(outstanding) + (CW+2)'(discard) + (CW+2)'(count);
    assign credit = used < (CW+2)'(DEPTH);

    assign imem_req_valid = credit && !redirect_valid && !reset;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (discard != '0);
    assign rsp_keep = imem_rsp_valid && (discard == '0);

    assign instr_valid = count != '0;
    assign push        = rsp_keep && !redirect_valid;
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        entry       = '0;
        entry.pc    = FETCH_XLEN'(rsp_pc);
        entry.instr = imem_rsp_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= target;
            rsp_pc      <= target;
            discard     <= discard + outstanding - CW'(imem_rsp_valid);
            outstanding <= '0;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_INC);
            if (rsp_keep) rsp_pc <= rsp_pc + XLEN'(PC_INC);
            if (rsp_drop) discard <= discard - 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .flush(redirect_valid),
        .din  (entry),
        .head (head),
        .count(count)
    );

    assign instr    = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc = instr_valid ? XLEN'(head.pc) : rsp_pc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (instr_ready && !instr_valid && stall_count != '1) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a stream-level reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk = 0;
    logic        reset = 1;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready = 0;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready = 0;
    logic        redirect_valid = 0;
    logic [63:0] redirect_pc = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_count;
`endif

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          epoch;
        int          due;
    } req_t;

    int tests = 0;
    int fails = 0;

    // memory and model state
    req_t        q[$];
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          buffered = 0;
    logic [63:0] exp_req_pc = RST_PC;
    logic [63:0] exp_rsp_pc = RST_PC;
    longint      exp_stall = 0;

    // knobs
    int p_rdy = 100;
    int p_irdy = 100;
    int p_redir = 0;
    int lat_min = 1;
    int lat_max = 1;
    bit force_redir = 0;
    logic [63:0] force_pc = 0;

    // observation records
    logic [63:0] fire_addr[$];
    int          fire_cyc[$];
    logic [63:0] deliv_pc[$];
    int          deliv_cyc[$];
    logic        iv_hist[$];
    logic        rv_hist[$];
    logic [31:0] stall_hist[$];
    logic        raw_pop;
    logic        raw_rsp;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC3A5_1E0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic clear_rec();
        fire_addr.delete();
        fire_cyc.delete();
        deliv_pc.delete();
        deliv_cyc.delete();
        iv_hist.delete();
        rv_hist.delete();
        stall_hist.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        imem_req_ready = 0;
        imem_rsp_valid = 0;
        instr_ready = 0;
        redirect_valid = 0;
        #1;
        chk("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_instr_valid", {63'b0, instr_valid}, 64'd0);
        chk("rst_instr", {32'b0, instr}, {32'b0, NOP_INSTR});
        chk("rst_instr_pc", instr_pc, RST_PC);
`ifdef FETCH_PERF_EN
        chk("rst_stall", {32'b0, stall_count}, 64'd0);
`endif
        q.delete();
        epoch++;
        cyc = 0;
        last_due = 0;
        buffered = 0;
        exp_req_pc = RST_PC;
        exp_rsp_pc = RST_PC;
        exp_stall = 0;
        force_redir = 0;
        @(negedge clk);
        reset = 0;
        #1;
        chk("rel_req_valid", {63'b0, imem_req_valid}, 64'd1);
    endtask

    task automatic cycle();
        logic        exp_rv;
        logic        exp_iv;
        logic        fire;
        logic        pop;
        logic        live;
        logic [63:0] tgt;
        int          lat;
        req_t        e;
        req_t        n;
        @(negedge clk);
        redirect_valid = force_redir || ($urandom_range(99) < p_redir);
        if (force_redir) redirect_pc = force_pc;
        else if ($urandom_range(7) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
        else redirect_pc = {$urandom, $urandom};
        force_redir = 0;
        imem_req_ready = $urandom_range(99) < p_rdy;
        instr_ready = $urandom_range(99) < p_irdy;
        if (q.size() > 0 && q[0].due <= cyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data = mem_word(q[0].addr);
        end else begin
            imem_rsp_valid = 0;
            imem_rsp_data = $urandom;
        end
        #1;
        exp_rv = (q.size() + buffered < DEPTH) && !redirect_valid;
        exp_iv = buffered != 0;
        chk("req_valid", {63'b0, imem_req_valid}, {63'b0, exp_rv});
        chk("req_addr", imem_req_addr, exp_req_pc);
        chk("instr_valid", {63'b0, instr_valid}, {63'b0, exp_iv});
        chk("instr_pc", instr_pc, exp_rsp_pc);
        chk("instr", {32'b0, instr},
            {32'b0, exp_iv ? mem_word(exp_rsp_pc) : NOP_INSTR});
`ifdef FETCH_PERF_EN
        chk("stall_count", {32'b0, stall_count}, 64'(exp_stall));
        stall_hist.push_back(stall_count);
`endif
        iv_hist.push_back(instr_valid);
        rv_hist.push_back(imem_req_valid);
        raw_pop = instr_valid && instr_ready;
        raw_rsp = imem_rsp_valid;

        fire = exp_rv && imem_req_ready;
        pop = exp_iv && instr_ready && !redirect_valid;
        live = 0;
        if (imem_rsp_valid) begin
            e = q.pop_front();
            live = (e.epoch == epoch);
        end
        if (instr_ready && !exp_iv && exp_stall < 64'hFFFF_FFFF)
            exp_stall++;
        if (redirect_valid) begin
            tgt = {redirect_pc[63:2], 2'b00};
            epoch++;
            exp_req_pc = tgt;
            exp_rsp_pc = tgt;
            buffered = 0;
        end else begin
            if (fire) begin
                lat = $urandom_range(lat_max, lat_min);
                n.addr = exp_req_pc;
                n.epoch = epoch;
                n.due = (cyc + lat > last_due) ? cyc + lat : last_due;
                last_due = n.due;
                q.push_back(n);
                fire_addr.push_back(exp_req_pc);
                fire_cyc.push_back(cyc);
                exp_req_pc = exp_req_pc + 64'd4;
            end
            if (live) buffered++;
            if (pop) begin
                deliv_pc.push_back(exp_rsp_pc);
                deliv_cyc.push_back(cyc);
                buffered--;
                exp_rsp_pc = exp_rsp_pc + 64'd4;
            end
        end
        cyc++;
    endtask

    task automatic knobs(input int rdy, input int irdy, input int redir,
                         input int lmin, input int lmax);
        p_rdy = rdy;
        p_irdy = irdy;
        p_redir = redir;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    initial begin
        // streaming from reset, 1-cycle memory
        knobs(100, 100, 0, 1, 1);
        do_reset();
        clear_rec();
        repeat (12) cycle();
        chk("t1_nfire", 64'(fire_addr.size() >= 3), 64'd1);
        if (fire_addr.size() >= 3) begin
            chk("t1_addr0", fire_addr[0], 64'h0);
            chk("t1_addr1", fire_addr[1], 64'h4);
            chk("t1_addr2", fire_addr[2], 64'h8);
            chk("t1_fire_cyc", 64'(fire_cyc[0]), 64'd0);
        end
        chk("t1_ndeliv", 64'(deliv_pc.size()), 64'd10);
        if (deliv_pc.size() > 0) begin
            chk("t1_first_pc", deliv_pc[0], 64'h0);
            chk("t1_first_cyc", 64'(deliv_cyc[0]), 64'd2);
        end

        // datapath backpressure fills credit
        knobs(100, 0, 0, 1, 1);
        do_reset();
        clear_rec();
        repeat (10) cycle();
        chk("t2_nfire", 64'(fire_addr.size()), 64'd4);
        chk("t2_rv_low", {63'b0, rv_hist[rv_hist.size()-1]}, 64'd0);
        knobs(100, 100, 0, 1, 1);
        clear_rec();
        repeat (10) cycle();
        chk("t2_ndeliv", 64'(deliv_pc.size() >= 4), 64'd1);
        if (deliv_pc.size() >= 4) begin
            chk("t2_d0", deliv_pc[0], 64'h0);
            chk("t2_d1", deliv_pc[1], 64'h4);
            chk("t2_d2", deliv_pc[2], 64'h8);
            chk("t2_d3", deliv_pc[3], 64'hC);
        end

        // redirect with three in flight
        knobs(100, 100, 0, 5, 5);
        do_reset();
        repeat (3) cycle();
        chk("t3_inflight", 64'(q.size()), 64'd3);
        force_redir = 1;
        force_pc = 64'h1002;
        clear_rec();
        repeat (16) cycle();
        chk("t3_nfire", 64'(fire_addr.size() > 0), 64'd1);
        if (fire_addr.size() > 0) begin
            chk("t3_addr", fire_addr[0], 64'h1000);
            chk("t3_fire_cyc", 64'(fire_cyc[0]), 64'd4);
        end
        chk("t3_ndeliv", 64'(deliv_pc.size() > 0), 64'd1);
        if (deliv_pc.size() > 0) chk("t3_first_pc", deliv_pc[0], 64'h1000);

        // redirect coinciding with pop and response
        knobs(100, 100, 0, 1, 1);
        do_reset();
        repeat (6) cycle();
        force_redir = 1;
        force_pc = 64'h2000;
        clear_rec();
        cycle();
        chk("t4_pop", {63'b0, raw_pop}, 64'd1);
        chk("t4_rsp", {63'b0, raw_rsp}, 64'd1);
        cycle();
        chk("t4_empty", {63'b0, iv_hist[1]}, 64'd0);
        repeat (10) cycle();
        chk("t4_ndeliv", 64'(deliv_pc.size() > 0), 64'd1);
        if (deliv_pc.size() > 0) chk("t4_first_pc", deliv_pc[0], 64'h2000);

        // address wrap
        knobs(100, 100, 0, 1, 1);
        do_reset();
        force_redir = 1;
        force_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        clear_rec();
        repeat (4) cycle();
        chk("t5_nfire", 64'(fire_addr.size() >= 2), 64'd1);
        if (fire_addr.size() >= 2) begin
            chk("t5_a0", fire_addr[0], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("t5_a1", fire_addr[1], 64'h0);
        end

`ifdef FETCH_PERF_EN
        knobs(0, 100, 0, 1, 1);
        do_reset();
        clear_rec();
        repeat (8) cycle();
        chk("t6_stall", {32'b0, stall_hist[7]}, 64'd7);
`endif

        // randomized traffic with redirects and resets
        knobs(70, 70, 3, 1, 6);
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(999) < 2) do_reset();
            else cycle();
            if (i == 2000) knobs(95, 95, 1, 1, 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
